// File: rtl/dac_i2s_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : dac_i2s_transmitter
//  Description : Serializes one stereo pair of signed PCM samples per frame
//                into an I2S (or left-justified) stream for an audio DAC.
//                Runs directly on the bit clock; all state moves on the
//                falling edge so the DAC can sample sd on the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_i2s_transmitter #(
    parameter int WIDTH     = 24,   // bits per channel sample, 8..32
    parameter int I2S_DELAY = 1     // 1 = standard I2S, 0 = left-justified
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] left_data,
    input  logic [WIDTH-1:0] right_data,
    output logic             sclk,
    output logic             lrclk,
    output logic             sd
);

    // ------------------------------------------------------------------------
    // Frame geometry
    // ------------------------------------------------------------------------
    localparam int              c_frame_len = 2 * WIDTH;
    localparam int              c_cnt_w     = $clog2(c_frame_len);
    localparam int              c_pair_w    = 2 * WIDTH;
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(c_frame_len - 1);
    localparam logic [c_cnt_w-1:0] c_half      = c_cnt_w'(WIDTH);
    // Slot in which the left MSB is driven: one bit after the LR edge for
    // I2S, coincident with it for left-justified.
    localparam logic [c_cnt_w-1:0] c_load_slot = c_cnt_w'((I2S_DELAY != 0) ? 1 : 0);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                 r_en_q;       // enable as seen on the falling edge
    logic                 r_run;        // a frame has been started since reset
    logic [c_cnt_w-1:0]   r_cnt;        // current bit slot within the frame
    logic                 r_lrclk;
    logic                 r_sd;
    logic [WIDTH-1:0]     r_left_sh;    // pair captured at slot 0
    logic [WIDTH-1:0]     r_right_sh;
    logic [c_pair_w-1:0]  r_shift;      // {left, right}, MSB goes out first

    logic [c_cnt_w-1:0]   w_cnt_next;
    logic                 w_capture;
    logic                 w_load;
    logic                 w_lrclk_next;
    logic [c_pair_w-1:0]  w_load_pair;

    // ------------------------------------------------------------------------
    // Source of the word loaded into the shift register.
    // With the one-bit delay the load happens one slot after the capture, so
    // it takes the shadow copy; left-justified loads in the capture edge
    // itself and therefore takes the ports directly.
    // ------------------------------------------------------------------------
    generate
        if (I2S_DELAY != 0) begin : g_src_shadow
            assign w_load_pair = {r_left_sh, r_right_sh};
        end else begin : g_src_direct
            assign w_load_pair = {left_data, right_data};
        end
    endgenerate

    // Next slot number and the per-slot decisions derived from it.
    // The first enabled edge after reset lands on slot 0 rather than 1.
    always_comb begin
        w_cnt_next   = '0;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_lrclk_next = 1'b0;
        if (r_run && (r_cnt != c_cnt_last)) begin
            w_cnt_next = r_cnt + c_cnt_w'(1);
        end
        w_capture    = (w_cnt_next == '0);
        w_load       = (w_cnt_next == c_load_slot);
        w_lrclk_next = (w_cnt_next >= c_half);
    end

    // Register enable on the falling edge so the gated sclk cannot glitch.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_en_q <= 1'b0;
        end else begin
            r_en_q <= enable;
        end
    end

    // Slot counter and channel select; both freeze while enable is low.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_cnt   <= '0;
            r_lrclk <= 1'b0;
        end else if (enable) begin
            r_run   <= 1'b1;
            r_cnt   <= w_cnt_next;
            r_lrclk <= w_lrclk_next;
        end
    end

    // Capture both channels together at the start of each frame so that
    // later input changes cannot tear the pair in flight.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_left_sh  <= '0;
            r_right_sh <= '0;
        end else if (enable && w_capture) begin
            r_left_sh  <= left_data;
            r_right_sh <= right_data;
        end
    end

    // Serializer: load the pair in the left-MSB slot, otherwise shift.
    // With the one-bit delay the right LSB is still in the top bit during
    // slot 0 of the next frame, which is exactly where it must appear.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_sd    <= 1'b0;
        end else if (enable) begin
            if (w_load) begin
                r_sd    <= w_load_pair[c_pair_w-1];
                r_shift <= {w_load_pair[c_pair_w-2:0], 1'b0};
            end else begin
                r_sd    <= r_shift[c_pair_w-1];
                r_shift <= {r_shift[c_pair_w-2:0], 1'b0};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. r_en_q only changes while clk is low, so the AND is clean.
    // ------------------------------------------------------------------------
    assign sclk  = clk & r_en_q;
    assign lrclk = r_lrclk;
    assign sd    = r_sd;

endmodule
`default_nettype wire

// File: tb/tb_dac_i2s_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dac_i2s_transmitter
//  Description : Self-checking bench for dac_i2s_transmitter. One instance in
//                standard I2S mode and one in left-justified mode share the
//                same stimulus; a slot-level model predicts lrclk/sd/sclk.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_i2s_transmitter;

    localparam int W = 24;
    localparam int F = 2 * W;

    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic         enable     = 1'b0;
    logic [W-1:0] left_data  = '0;
    logic [W-1:0] right_data = '0;
    logic         sclk_a, lrclk_a, sd_a;
    logic         sclk_b, lrclk_b, sd_b;

    int n_cmp = 0;
    int n_bad = 0;

    // Slot-level model state
    bit           m_started  = 1'b0;
    int           m_cnt      = 0;
    logic [W-1:0] m_l        = '0;
    logic [W-1:0] m_r        = '0;
    logic         m_prev_lsb = 1'b0;
    logic         m_en       = 1'b0;
    logic         exp_lr     = 1'b0;
    logic         exp_sd1    = 1'b0;
    logic         exp_sd0    = 1'b0;

    // Bits seen by the DAC (sd at sclk rising), indexed by slot
    logic bits_a [F];
    logic bits_b [F];

    always #5 clk = ~clk;

    dac_i2s_transmitter #(.WIDTH(W), .I2S_DELAY(1)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .left_data  (left_data),
        .right_data (right_data),
        .sclk       (sclk_a),
        .lrclk      (lrclk_a),
        .sd         (sd_a)
    );

    dac_i2s_transmitter #(.WIDTH(W), .I2S_DELAY(0)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .left_data  (left_data),
        .right_data (right_data),
        .sclk       (sclk_b),
        .lrclk      (lrclk_b),
        .sd         (sd_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model: decide the slot, capture at slot 0, pick the bit from the rules.
    always begin
        @(negedge clk or posedge rst);
        if (rst) begin
            m_started  = 1'b0;
            m_cnt      = 0;
            m_l        = '0;
            m_r        = '0;
            m_prev_lsb = 1'b0;
            m_en       = 1'b0;
            exp_lr     = 1'b0;
            exp_sd1    = 1'b0;
            exp_sd0    = 1'b0;
        end else begin
            m_en = enable;
            if (enable) begin
                if (!m_started) begin
                    m_started = 1'b1;
                    m_cnt     = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % F;
                end
                if (m_cnt == 0) begin
                    m_prev_lsb = m_r[0];
                    m_l        = left_data;
                    m_r        = right_data;
                end
                exp_lr  = (m_cnt >= W);
                if (m_cnt == 0)      exp_sd1 = m_prev_lsb;
                else if (m_cnt <= W) exp_sd1 = m_l[W - m_cnt];
                else                 exp_sd1 = m_r[2 * W - m_cnt];
                if (m_cnt < W)       exp_sd0 = m_l[W - 1 - m_cnt];
                else                 exp_sd0 = m_r[2 * W - 1 - m_cnt];
            end
        end
        #1;
        check("sd_i2s",     64'(sd_a),    64'(exp_sd1));
        check("lrclk_i2s",  64'(lrclk_a), 64'(exp_lr));
        check("sd_lj",      64'(sd_b),    64'(exp_sd0));
        check("lrclk_lj",   64'(lrclk_b), 64'(exp_lr));
        check("sclk_low_a", 64'(sclk_a),  64'(0));
        check("sclk_low_b", 64'(sclk_b),  64'(0));
    end

    // High phase: sclk follows the registered enable; record DAC-sampled bits.
    always begin
        @(posedge clk);
        #1;
        check("sclk_high_a", 64'(sclk_a), 64'(m_en));
        check("sclk_high_b", 64'(sclk_b), 64'(m_en));
        if (m_en) begin
            bits_a[m_cnt] = sd_a;
            bits_b[m_cnt] = sd_b;
        end
    end

    function automatic logic [W-1:0] left_slots_a();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[W-1-i] = bits_a[1+i];
        return v;
    endfunction

    function automatic logic [W-1:0] right_slots_a();
        logic [W-1:0] v;
        for (int i = 0; i < W - 1; i++) v[W-1-i] = bits_a[W+1+i];
        v[0] = bits_a[0];
        return v;
    endfunction

    function automatic logic [W-1:0] left_slots_b();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[W-1-i] = bits_b[i];
        return v;
    endfunction

    // Returns at posedge+2 of the requested slot, or records a timeout.
    task automatic wait_cnt(input int target, input string name);
        for (int i = 0; i < 4 * F; i++) begin
            @(posedge clk);
            #2;
            if (m_started && m_cnt == target) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL timeout_%s: actual=no_slot required=slot_%0d", name, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        // Reset with the clock running
        rst    = 1'b1;
        enable = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("reset_sd",    64'(sd_a),    64'(0));
        check("reset_lrclk", 64'(lrclk_a), 64'(0));
        check("reset_sclk",  64'(sclk_a),  64'(0));

        // Known pattern on the first frames after release
        left_data  = 24'h800001;
        right_data = 24'h7FFFFE;
        enable     = 1'b1;
        rst        = 1'b0;
        repeat (F + 1) @(negedge clk);
        @(posedge clk);
        #2;
        check("pattern_left",    64'(left_slots_a()),  64'(24'h800001));
        check("pattern_right",   64'(right_slots_a()), 64'(24'h7FFFFE));
        check("pattern_left_lj", 64'(left_slots_b()),  64'(24'h800001));

        // lrclk duty over one frame
        hi = 0;
        repeat (F) begin
            @(posedge clk);
            #2;
            hi += int'(lrclk_a);
        end
        check("lrclk_duty", 64'(hi), 64'(W));

        // Mid-frame input change only takes effect at the next capture
        wait_cnt(10, "cnt10");
        left_data = 24'h123456;
        wait_cnt(25, "cnt25a");
        check("midframe_old", 64'(left_slots_a()), 64'(24'h800001));
        wait_cnt(25, "cnt25b");
        check("midframe_new", 64'(left_slots_a()), 64'(24'h123456));

        // Enable pause at slot 30 for 5 clocks
        wait_cnt(30, "cnt30");
        enable = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #2;
            check("pause_sclk",  64'(sclk_a),  64'(0));
            check("pause_lrclk", 64'(lrclk_a), 64'(1));
        end
        enable = 1'b1;
        wait_cnt(0, "cnt0_after_pause");
        check("pause_right", 64'(right_slots_a()), 64'(24'h7FFFFE));

        // Randomized data and enable
        repeat (600) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 3) == 0) left_data  = W'($urandom);
            if ($urandom_range(0, 3) == 0) right_data = W'($urandom);
            enable = ($urandom_range(0, 7) != 0);
        end
        enable = 1'b1;

        // Asynchronous reset between edges at slot 17, while sclk is high
        wait_cnt(17, "cnt17");
        rst = 1'b1;
        #1;
        check("async_rst_sd",     64'(sd_a),    64'(0));
        check("async_rst_sclk",   64'(sclk_a),  64'(0));
        check("async_rst_lrclk",  64'(lrclk_a), 64'(0));
        check("async_rst_sd_lj",  64'(sd_b),    64'(0));
        repeat (3) @(posedge clk);
        #2;
        left_data  = 24'hA5A5A5;
        right_data = W'($urandom);
        rst        = 1'b0;
        repeat (W + 1) @(posedge clk);
        #2;
        check("lj_a5_left",   64'(left_slots_b()), 64'(24'hA5A5A5));
        check("i2s_a5_left",  64'(left_slots_a()), 64'(24'hA5A5A5));
        check("fresh_slot0",  64'(bits_a[0]),      64'(0));

        repeat (2 * F) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
